// File: rtl/sc_shift_seq.sv
// rtl/sc_shift_seq.sv - shift-count loop sequencer (IDLE/RUN/DONE) issuing datapath shift steps
module sc_shift_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [0:9] count,
  input  logic       norm_mode,
  input  logic       norm_hit,
  input  logic       hold,
  input  logic       abort,
  output logic       busy,
  output logic       shift_en,
  output logic       done,
  output logic [0:9] SC,
  output logic [0:5] steps,
  output logic       sat,
  output logic       norm_stop
);

  // Largest shift a single loop may perform; larger positive counts are clamped.
  localparam logic [9:0] SC_MAX    = 10'd36;
  localparam logic [5:0] STEPS_MAX = 6'd36;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] sc_q, sc_d;
  logic [5:0] steps_q, steps_d;
  logic       sat_q, sat_d;
  logic       norm_stop_q, norm_stop_d;
  logic       norm_mode_q, norm_mode_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       shift_en_c;

  // Count arrives with bit 0 as the sign; work internally with a descending range.
  logic [9:0] count_v;
  logic       count_neg;
  logic       count_zero;
  logic       count_big;

  assign count_v = count;

  // Classify the requested count for the load decision.
  always_comb begin
    count_neg  = count_v[9];
    count_zero = (count_v == 10'd0);
    count_big  = !count_v[9] && (count_v >= SC_MAX);
  end

  // Next-state and datapath control: load in IDLE, prioritised step loop in RUN.
  always_comb begin
    state_d     = state_q;
    sc_d        = sc_q;
    steps_d     = steps_q;
    sat_d       = sat_q;
    norm_stop_d = norm_stop_q;
    norm_mode_d = norm_mode_q;
    shift_en_c  = 1'b0;
    done_d      = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          steps_d     = 6'd0;
          norm_mode_d = norm_mode;
          sat_d       = 1'b0;
          norm_stop_d = 1'b0;
          if (count_neg || count_zero) begin
            // Nothing to shift: report completion straight away.
            sc_d    = count_v;
            state_d = ST_DONE;
          end else if (count_big) begin
            sc_d    = SC_MAX;
            sat_d   = 1'b1;
            state_d = ST_RUN;
          end else begin
            sc_d    = count_v;
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (abort) begin
          // Cancel silently; SC and steps keep the partial progress.
          state_d = ST_IDLE;
        end else if (hold) begin
          state_d = ST_RUN;
        end else if (norm_mode_q && norm_hit) begin
          norm_stop_d = 1'b1;
          state_d     = ST_DONE;
        end else if (sc_q == 10'd0) begin
          // Cannot occur from a legal load; finish rather than underflow SC.
          state_d = ST_DONE;
        end else begin
          shift_en_c = 1'b1;
          sc_d       = sc_q - 10'd1;
          if (steps_q != STEPS_MAX) begin
            steps_d = steps_q + 6'd1;
          end
          if (sc_q == 10'd1) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flag outputs are registered decodes of the state being entered.
    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  // State and result registers; reset abandons any loop without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sc_q        <= 10'd0;
      steps_q     <= 6'd0;
      sat_q       <= 1'b0;
      norm_stop_q <= 1'b0;
      norm_mode_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sc_q        <= sc_d;
      steps_q     <= steps_d;
      sat_q       <= sat_d;
      norm_stop_q <= norm_stop_d;
      norm_mode_q <= norm_mode_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign shift_en  = shift_en_c;
  assign done      = done_q;
  assign SC        = sc_q;
  assign steps     = steps_q;
  assign sat       = sat_q;
  assign norm_stop = norm_stop_q;

endmodule

// File: tb/tb_sc_shift_seq.sv
// tb/tb_sc_shift_seq.sv - scoreboard bench for sc_shift_seq with randomized loops
module tb_sc_shift_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [9:0] count = 10'd0;
  logic       norm_mode = 1'b0;
  logic       norm_hit = 1'b0;
  logic       hold = 1'b0;
  logic       abort = 1'b0;
  logic       busy;
  logic       shift_en;
  logic       done;
  logic [9:0] SC;
  logic [5:0] steps;
  logic       sat;
  logic       norm_stop;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           len;
    bit           ended_done;
    logic [255:0] mask;
    logic [9:0]   sc;
    int           steps;
    bit           sat;
    bit           ns;
  } exp_t;

  exp_t exp_q[$];
  bit   hold_a[256];
  bit   abort_a[256];
  bit   nh_a[256];
  bit   mon_en = 1'b0;
  int   idle_glitch = 0;

  sc_shift_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .count     (count),
    .norm_mode (norm_mode),
    .norm_hit  (norm_hit),
    .hold      (hold),
    .abort     (abort),
    .busy      (busy),
    .shift_en  (shift_en),
    .done      (done),
    .SC        (SC),
    .steps     (steps),
    .sat       (sat),
    .norm_stop (norm_stop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the RUN cycles of one loop applying the priority rules.
  function automatic exp_t model(input logic [9:0] cnt, input bit nm);
    exp_t e;
    int   rem;
    e.len = 0; e.ended_done = 1'b0; e.mask = '0; e.sc = cnt;
    e.steps = 0; e.sat = 1'b0; e.ns = 1'b0;
    if (cnt[9] || cnt == 10'd0) begin
      e.len = 1;
      e.ended_done = 1'b1;
      return e;
    end
    rem   = (cnt >= 10'd36) ? 36 : int'(cnt);
    e.sat = (cnt >= 10'd36);
    for (int j = 0; j < 255; j++) begin
      if (abort_a[j]) begin
        e.len = j + 1;
        break;
      end
      if (hold_a[j]) continue;
      if (nm && nh_a[j]) begin
        e.ns = 1'b1;
        e.len = j + 2;
        e.ended_done = 1'b1;
        break;
      end
      e.mask[j] = 1'b1;
      rem = rem - 1;
      e.steps = e.steps + 1;
      if (rem == 0) begin
        e.len = j + 2;
        e.ended_done = 1'b1;
        break;
      end
    end
    e.sc = 10'(rem);
    return e;
  endfunction

  // Monitor: observe each busy window and compare it with the next expectation.
  int           m_off = 0;
  logic [255:0] m_mask = '0;
  int           m_done_cnt = 0;
  int           m_done_off = -1;
  logic         m_busy_prev = 1'b0;
  exp_t         m_e;

  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (busy && !m_busy_prev) begin
        m_off = 0; m_mask = '0; m_done_cnt = 0; m_done_off = -1;
      end
      if (busy) begin
        if (shift_en && m_off < 256) m_mask[m_off] = 1'b1;
        if (done) begin
          m_done_cnt++;
          m_done_off = m_off;
        end
        m_off++;
      end else if (shift_en || done) begin
        idle_glitch++;
      end
      if (!busy && m_busy_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_end: got loop end expected none pending");
        end else begin
          m_e = exp_q.pop_front();
          chk("busy_cycles", m_off, m_e.len);
          chk("done_pulses", m_done_cnt, m_e.ended_done ? 1 : 0);
          if (m_e.ended_done) chk("done_cycle", m_done_off, m_e.len - 1);
          checks++;
          if (m_mask !== m_e.mask) begin
            errors++;
            $display("FAIL shift_en_pattern: got %h expected %h", m_mask, m_e.mask);
          end
          chk("SC", SC, m_e.sc);
          chk("steps", steps, m_e.steps);
          chk("sat", sat, m_e.sat);
          chk("norm_stop", norm_stop, m_e.ns);
        end
      end
    end
    m_busy_prev = busy;
  end

  task automatic clear_arrays();
    for (int j = 0; j < 256; j++) begin
      hold_a[j] = 1'b0; abort_a[j] = 1'b0; nh_a[j] = 1'b0;
    end
  endtask

  task automatic fill_random(input bit with_abort);
    for (int j = 0; j < 256; j++) begin
      hold_a[j]  = (j < 200) && ($urandom_range(0, 7) == 0);
      abort_a[j] = with_abort && ($urandom_range(0, 29) == 0);
      nh_a[j]    = ($urandom_range(0, 9) == 0);
    end
  endtask

  // gmode: 0 no start while busy, 1 occasional, 2 every busy cycle.
  task automatic run_txn(input logic [9:0] cnt, input bit nm, input int gmode);
    exp_t e;
    e = model(cnt, nm);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b1; count = cnt; norm_mode = nm;
    hold = 1'b0; abort = 1'b0; norm_hit = 1'b0;
    @(posedge clk);
    for (int j = 0; j < e.len; j++) begin
      @(negedge clk);
      hold      = hold_a[j];
      abort     = abort_a[j];
      norm_hit  = nh_a[j];
      norm_mode = 1'($urandom_range(0, 1));
      start     = (gmode == 2) || (gmode == 1 && $urandom_range(0, 3) == 0);
      count     = 10'($urandom);
    end
    @(negedge clk);
    start = 1'b0; hold = 1'b0; abort = 1'b0; norm_hit = 1'b0; count = 10'd0;
  endtask

  function automatic logic [9:0] pick_count();
    case ($urandom_range(0, 9))
      0:       return 10'd0;
      1:       return 10'h200 | 10'($urandom_range(0, 511));
      2:       return 10'd36;
      3:       return 10'($urandom_range(37, 511));
      4:       return 10'd1;
      default: return 10'($urandom_range(1, 35));
    endcase
  endfunction

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat, 0);
    chk("rst_norm_stop", norm_stop, 0);
    chk("rst_SC", SC, 0);
    chk("rst_steps", steps, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    clear_arrays(); run_txn(10'd5, 1'b0, 2);
    #3; chk("c5_SC", SC, 0); chk("c5_steps", steps, 5); chk("c5_sat", sat, 0);
    clear_arrays(); run_txn(10'd0, 1'b0, 0);
    #3; chk("c0_steps", steps, 0); chk("c0_SC", SC, 0);
    clear_arrays(); run_txn(10'h3FD, 1'b0, 0);
    #3; chk("cneg_SC", SC, 10'h3FD); chk("cneg_steps", steps, 0);
    clear_arrays(); run_txn(10'd100, 1'b0, 1);
    #3; chk("c100_sat", sat, 1); chk("c100_steps", steps, 36); chk("c100_SC", SC, 0);
    clear_arrays(); nh_a[2] = 1'b1; run_txn(10'd10, 1'b1, 0);
    #3; chk("norm_ns", norm_stop, 1); chk("norm_steps", steps, 2); chk("norm_SC", SC, 8);
    clear_arrays(); hold_a[1] = 1'b1; abort_a[3] = 1'b1; run_txn(10'd4, 1'b0, 0);
    #3; chk("abort_steps", steps, 2); chk("abort_SC", SC, 2); chk("abort_ns", norm_stop, 0);

    // Start during RUN is ignored; reset mid-loop clears everything at once.
    mon_en = 1'b0;
    @(negedge clk); start = 1'b1; count = 10'd5; norm_mode = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b1; count = 10'd0;
    @(posedge clk);
    #1;
    chk("run_start_busy", busy, 1); chk("run_start_done", done, 0); chk("run_start_SC", SC, 4);
    start = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0); chk("mid_rst_shift_en", shift_en, 0);
    chk("mid_rst_done", done, 0); chk("mid_rst_SC", SC, 0); chk("mid_rst_steps", steps, 0);
    @(negedge clk);
    reset = 1'b0; start = 1'b1; count = 10'd1;
    @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 1); chk("post_rst_shift_en", shift_en, 1);
    @(negedge clk); start = 1'b0; count = 10'd0;
    for (int t = 0; t < 10 && busy; t++) @(negedge clk);
    chk("post_rst_idle", busy, 0);
    @(negedge clk);
    mon_en = 1'b1;

    for (int n = 0; n < 150; n++) begin
      fill_random($urandom_range(0, 3) == 0);
      run_txn(pick_count(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    chk("idle_glitches", idle_glitch, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_shift_seq.md
SC_SHIFT_SEQ -- requirements
Module: sc_shift_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock, with all state changing on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request to begin a shift-count loop; sampled only in IDLE.
REQ-004 SHALL have port count, input, [0:9]: signed two's-complement shift count (bit 0 is the sign), SCAD result format.
REQ-005 SHALL have port norm_mode, input, 1 bit: enables early termination on norm_hit; sampled at start.
REQ-006 SHALL have port norm_hit, input, 1 bit: normalize condition from the datapath (AR leading bit).
REQ-007 SHALL have port hold, input, 1 bit: stall; freezes the loop for the cycle.
REQ-008 SHALL have port abort, input, 1 bit: cancels the loop.
REQ-009 SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-010 SHALL have port shift_en, output, 1 bit: one datapath shift step this cycle.
REQ-011 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-012 SHALL have port SC, output, [0:9]: remaining shift count register.
REQ-013 SHALL have port steps, output, [0:5]: number of shift_en cycles issued in the current or last loop.
REQ-014 SHALL have port sat, output, 1 bit: the loaded count was at least 36 and was clamped.
REQ-015 SHALL have port norm_stop, output, 1 bit: the loop ended on norm_hit.

Function
REQ-016 SHALL implement three states: IDLE, RUN and DONE.
REQ-017 In IDLE with start=1, SHALL clear steps, latch norm_mode, and set sat and norm_stop to 0, except as stated in REQ-018.
REQ-018 In IDLE with start=1, SHALL take the load action by count:
- count sign=1 or count=0: load SC=count, go to DONE.
- count in 1..35: load SC=count, go to RUN.
- count of 36 or more: load SC=36, set sat=1, go to RUN.
REQ-019 In RUN, the actions SHALL be evaluated with the priority abort > hold > norm_hit (when the latched norm_mode=1) > step.
REQ-020 In RUN with abort=1: shift_en=0, go to IDLE, no done pulse; SC and steps are held.
REQ-021 In RUN with hold=1: shift_en=0; SC, steps and state are unchanged.
REQ-022 In RUN with latched norm_mode=1 and norm_hit=1: shift_en=0, set norm_stop=1, go to DONE.
REQ-023 In RUN on a step: shift_en=1, SC decrements by 1, steps increments by 1; go to DONE when SC was 1 before the decrement.
REQ-024 shift_en SHALL be combinational from the state and the RUN inputs; all other outputs SHALL be registered.
REQ-025 In DONE: done=1 for exactly one cycle, then go to IDLE; start is ignored in DONE.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 Latency: start at cycle N with count=k (1..36) and no hold SHALL give shift_en in cycles N+1..N+k and done in cycle N+k+1.
REQ-028 A zero or negative count SHALL give done in cycle N+1 with no shift_en.
REQ-029 Each hold cycle SHALL extend the latency by one cycle.
REQ-030 SC arithmetic SHALL be 10-bit; SC SHALL never decrement below 0 within a loop.
REQ-031 steps SHALL never exceed 36.
REQ-032 SC, steps, sat and norm_stop SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-033 While reset=1, asynchronously: state=IDLE; busy, shift_en, done, sat and norm_stop = 0; SC=0; steps=0.
REQ-034 Reset asserted mid-loop SHALL abandon the loop with no done pulse.
REQ-035 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-036 start with count=5 at cycle N -> shift_en high in N+1..N+5; done in N+6; SC=0, steps=5, sat=0.
REQ-037 count=0 -> done in N+1, no shift_en, steps=0.
REQ-038 count=0x3FD (-3) -> done in N+1, no shift_en, SC=0x3FD.
REQ-039 count=100 -> sat=1, SC loads 36, 36 shift_en cycles, done in N+37, steps=36.
REQ-040 norm_mode=1, count=10, norm_hit asserted in N+3 -> shift_en in N+1..N+2 only; done in N+4; norm_stop=1, steps=2, SC=8.
REQ-041 count=4 with hold in N+2 and abort in N+4 -> shift_en in N+1 and N+3 only; IDLE in N+5, no done, steps=2.
REQ-042 A start during RUN SHALL be ignored, and reset in N+2 of a count=5 loop SHALL give all outputs 0 immediately.
